im_fetch_ctrl: RTL and testbench
================================

// Module: im_fetch_ctrl
// PURPOSE
//  PC sequencer and fetch controller for the instruction memory.
//  - Holds the fetch PC and drives the IM word address.
//  - Applies redirects: exception entry, eret, branch/jump, sequential.
//  - Buffers a redirect that arrives while the front end is stalled.
//  - Flags fetch address errors (AdEL) and presents {pc, instr, exccode, valid} to the IF/ID register.
// PARAMETERS
//  PC_RESET      32'h0000_3000  PC loaded on reset
//  HANDLER_ADDR  32'h0000_4180  exception/interrupt entry PC
//  IM_BASE       32'h0000_3000  byte address of IM word 0
//  IM_WORDS      4096           IM depth in words; legal PCs are IM_BASE .. IM_BASE+4*IM_WORDS-4
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-high
//  stall       in   1   hazard unit: hold PC and IF outputs
//  br_valid    in   1   branch/jump taken this cycle
//  br_target   in   32  branch/jump target PC
//  exc_req     in   1   CP0: take exception/interrupt now
//  eret_req    in   1   eret in flight: return to epc
//  epc         in   32  CP0 EPC value
//  im_addr     out  32  byte address to IM (= pc)
//  im_instr    in   32  IM read data (combinational on im_addr)
//  if_pc       out  32  PC of the presented instruction
//  if_instr    out  32  instruction to IF/ID (0 = nop when invalid or AdEL)
//  if_exccode  out  5   5'd4 = AdEL, else 5'd0
//  if_valid    out  1   presented instruction is real (not a bubble)
//  fetch_cnt   out  32  count of PC advances since reset
// BEHAVIOUR
//  Reset (synchronous, takes effect at the edge):
//  - pc = PC_RESET, state = S_INIT, pend_valid = 0, fetch_cnt = 0.
//  FSM:
//  - S_INIT: one cycle. if_valid = 0, if_instr = 0. Next state is always S_RUN; pc is unchanged.
//  - S_RUN: if_valid = 1. Next pc is chosen each edge by this priority:
//    1. exc_req          -> pc = HANDLER_ADDR; pend_valid cleared (overrides stall)
//    2. eret_req         -> pc = epc; pend_valid cleared (overrides stall)
//    3. stall            -> pc held; if br_valid, latch pend = br_target and pend_valid = 1
//    4. pend_valid       -> pc = pend; pend_valid cleared (br_valid is ignored this cycle)
//    5. br_valid         -> pc = br_target
//    6. otherwise        -> pc = pc + 4 (32-bit wrap, no saturation)
//  - A new br_valid during stall with pend_valid already set overwrites pend (last one wins).
//  - reset in S_RUN returns to S_INIT on the next edge; pending redirect is discarded.
//  Outputs (combinational from registers):
//  - im_addr = pc; if_pc = pc.
//  - adel = (pc[1:0] != 0) | (pc < IM_BASE) | (pc > IM_BASE + 4*IM_WORDS - 4).
//  - if_exccode = (S_RUN & adel) ? 4 : 0.
//  - if_instr = (S_RUN & !adel) ? im_instr : 32'h0.
//  - An AdEL fetch is still presented with if_valid = 1. The PC keeps sequencing until CP0 asserts exc_req.
//  Counter:
//  - fetch_cnt increments on every S_RUN edge where pc changes for rules 4-6.
//  - Exception and eret redirects are not counted. Wraps at 2^32.
//  Zero-latency address path; IM read is combinational, so instr is valid in the same cycle as pc.
// TESTING
//  1. reset high 2 cycles, release, run 4 cycles -> if_valid 0 then 1; if_pc 3000, 3004, 3008; fetch_cnt = 2 after 3008 is presented.
//  2. stall high 3 cycles at pc 300c -> if_pc stays 300c; fetch_cnt frozen; release -> 3010.
//  3. br_valid, br_target 3100 while stall high; release stall next cycle -> pc 3100 exactly one cycle after release; pend_valid 0.
//  4. exc_req with stall high and pend_valid 1 -> pc 4180 next edge; pend discarded; following pc 4184.
//  5. eret_req, epc 3002 -> pc 3002; if_exccode 4; if_instr 0; if_valid 1. Repeat with epc 7000 -> AdEL.
//  6. reset asserted mid-run at pc 3020 with pending branch -> pc 3000; S_INIT bubble; pending branch never taken.

Source files
------------

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: PC sequencer and fetch controller for the instruction memory.
//
// Holds the fetch PC and drives the IM word address. Each cycle it picks the
// next PC from the exception, eret, branch/jump and sequential redirects. A
// branch that arrives while the front end is stalled is buffered until the
// stall lifts. Fetches from a misaligned or out-of-range PC are flagged as
// AdEL. The module presents {pc, instr, exccode, valid} to the IF/ID register.
//
// Ports:
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-high
//   stall       in   1   hold PC and IF outputs
//   br_valid    in   1   branch/jump taken this cycle
//   br_target   in   32  branch/jump target PC
//   exc_req     in   1   take exception/interrupt now
//   eret_req    in   1   return to epc
//   epc         in   32  EPC value
//   im_addr     out  32  byte address to IM (= pc)
//   im_instr    in   32  IM read data (combinational on im_addr)
//   if_pc       out  32  PC of the presented instruction
//   if_instr    out  32  instruction to IF/ID (0 when invalid or AdEL)
//   if_exccode  out  5   5'd4 = AdEL, else 0
//   if_valid    out  1   presented instruction is real
//   fetch_cnt   out  32  count of PC advances since reset
module im_fetch_ctrl #(
    parameter logic [31:0] PC_RESET     = 32'h0000_3000,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE      = 32'h0000_3000,
    parameter int unsigned IM_WORDS     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [4:0]  if_exccode,
    output logic        if_valid,
    output logic [31:0] fetch_cnt
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    // The last legal PC is computed in 33 bits so that a large IM_BASE
    // cannot overflow the bound.
    localparam logic [32:0] IM_LAST = {1'b0, IM_BASE} + 33'(4 * IM_WORDS) - 33'd4;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] cnt_q, cnt_d;
    logic        adel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            pc_q         <= PC_RESET;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_INIT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (exc_req) begin
                    // Exception and eret redirects win over stall and are not counted.
                    pc_d         = HANDLER_ADDR;
                    pend_valid_d = 1'b0;
                end else if (eret_req) begin
                    pc_d         = epc;
                    pend_valid_d = 1'b0;
                end else if (stall) begin
                    // Hold the PC; the latest branch seen during the stall wins.
                    if (br_valid) begin
                        pend_d       = br_target;
                        pend_valid_d = 1'b1;
                    end
                end else if (pend_valid_q) begin
                    // A buffered redirect takes precedence over a fresh branch.
                    pc_d         = pend_q;
                    pend_valid_d = 1'b0;
                    cnt_d        = cnt_q + 32'd1;
                end else if (br_valid) begin
                    pc_d  = br_target;
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    pc_d  = pc_q + 32'd4;
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_comb begin
        adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} > IM_LAST);
    end

    assign im_addr    = pc_q;
    assign if_pc      = pc_q;
    assign if_valid   = (state_q == S_RUN);
    assign if_exccode = (state_q == S_RUN && adel) ? EXC_ADEL : 5'd0;
    assign if_instr   = (state_q == S_RUN && !adel) ? im_instr : 32'h0;
    assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: directed scenarios and a randomized run of im_fetch_ctrl,
// with outputs checked against a behavioural model of the PC sequencing rules.
module tb_im_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, br_valid, exc_req, eret_req;
    logic [31:0] br_target, epc;
    logic [31:0] im_addr, im_instr, if_pc, if_instr, fetch_cnt;
    logic [4:0]  if_exccode;
    logic        if_valid;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Behavioural model: running flag, PC, at most one pending redirect, counter.
    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    // IM content is an arbitrary, address-unique function of the address.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign im_instr = im_word(im_addr);

    im_fetch_ctrl #(
        .PC_RESET    (32'h0000_3000),
        .HANDLER_ADDR(32'h0000_4180),
        .IM_BASE     (32'h0000_3000),
        .IM_WORDS    (4096)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .epc       (epc),
        .im_addr   (im_addr),
        .im_instr  (im_instr),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_exccode(if_exccode),
        .if_valid  (if_valid),
        .fetch_cnt (fetch_cnt)
    );

    function automatic bit addr_err(input logic [31:0] a);
        longint unsigned v;
        v = longint'(a);
        return (v % 4 != 0) || (v < 64'h3000) || (v > 64'h3000 + 4 * 4096 - 4);
    endfunction

    // Advance one clock and apply the same edge to the model.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_run = 1'b0;
            m_pc  = 32'h3000;
            m_pend.delete();
            m_cnt = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (exc_req) begin
            m_pc = 32'h4180;
            m_pend.delete();
        end else if (eret_req) begin
            m_pc = epc;
            m_pend.delete();
        end else if (stall) begin
            if (br_valid) begin
                m_pend.delete();
                m_pend.push_back(br_target);
            end
        end else begin
            if (m_pend.size() != 0) m_pc = m_pend.pop_front();
            else if (br_valid)      m_pc = br_target;
            else                    m_pc = m_pc + 4;
            m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; br_valid = 0; exc_req = 0; eret_req = 0;
        br_target = '0; epc = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        n_chk++; if (if_pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h expected 00003000", if_pc); end
        n_chk++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", if_instr); end
        n_chk++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", fetch_cnt); end
        reset = 0;
        step();
        n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3000) begin n_fail++; $display("FAIL run_first: got valid %b pc %h expected 1 00003000", if_valid, if_pc); end
        n_chk++; if (if_instr !== im_word(32'h3000)) begin n_fail++; $display("FAIL run_instr: got %h expected %h", if_instr, im_word(32'h3000)); end
        step();
        n_chk++; if (if_pc !== 32'h3004) begin n_fail++; $display("FAIL seq_3004: got %h expected 00003004", if_pc); end
        step();
        n_chk++; if (if_pc !== 32'h3008 || fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL seq_3008: got pc %h cnt %0d expected 00003008 2", if_pc, fetch_cnt); end
    endtask

    task automatic test_stall();
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (if_pc !== 32'h300c || fetch_cnt !== 32'd3 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got pc %h cnt %0d valid %b expected 0000300c 3 1", if_pc, fetch_cnt, if_valid); end
        end
        stall = 0;
        step();
        n_chk++; if (if_pc !== 32'h3010 || fetch_cnt !== 32'd4) begin n_fail++; $display("FAIL stall_release: got pc %h cnt %0d expected 00003010 4", if_pc, fetch_cnt); end
    endtask

    task automatic test_pending_branch();
        stall = 1; br_valid = 1; br_target = 32'h3100;
        step();
        n_chk++; if (if_pc !== 32'h3010) begin n_fail++; $display("FAIL pend_hold: got %h expected 00003010", if_pc); end
        stall = 0; br_valid = 0;
        step();
        n_chk++; if (if_pc !== 32'h3100 || fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL pend_taken: got pc %h cnt %0d expected 00003100 5", if_pc, fetch_cnt); end
        step();
        n_chk++; if (if_pc !== 32'h3104 || fetch_cnt !== 32'd6) begin n_fail++; $display("FAIL pend_cleared: got pc %h cnt %0d expected 00003104 6", if_pc, fetch_cnt); end
    endtask

    task automatic test_exception();
        stall = 1; br_valid = 1; br_target = 32'h3200;
        step();
        br_valid = 0; exc_req = 1;
        step();
        n_chk++; if (if_pc !== 32'h4180 || fetch_cnt !== 32'd6 || if_exccode !== 5'd0) begin n_fail++; $display("FAIL exc_entry: got pc %h cnt %0d exc %0d expected 00004180 6 0", if_pc, fetch_cnt, if_exccode); end
        exc_req = 0; stall = 0;
        step();
        n_chk++; if (if_pc !== 32'h4184 || fetch_cnt !== 32'd7) begin n_fail++; $display("FAIL exc_pend_dropped: got pc %h cnt %0d expected 00004184 7", if_pc, fetch_cnt); end
    endtask

    task automatic test_eret_adel();
        eret_req = 1; epc = 32'h3002;
        step();
        n_chk++; if (if_pc !== 32'h3002 || if_exccode !== 5'd4 || if_instr !== 32'h0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL eret_misalign: got pc %h exc %0d instr %h valid %b expected 00003002 4 0 1", if_pc, if_exccode, if_instr, if_valid); end
        n_chk++; if (fetch_cnt !== 32'd7) begin n_fail++; $display("FAIL eret_not_counted: got %0d expected 7", fetch_cnt); end
        epc = 32'h7000;
        step();
        n_chk++; if (if_pc !== 32'h7000 || if_exccode !== 5'd4 || if_instr !== 32'h0) begin n_fail++; $display("FAIL eret_above: got pc %h exc %0d instr %h expected 00007000 4 0", if_pc, if_exccode, if_instr); end
        epc = 32'h6ffc;
        step();
        n_chk++; if (if_exccode !== 5'd0 || if_instr !== im_word(32'h6ffc)) begin n_fail++; $display("FAIL last_legal: got exc %0d instr %h expected 0 %h", if_exccode, if_instr, im_word(32'h6ffc)); end
        eret_req = 0;
        step();
        n_chk++; if (if_pc !== 32'h7000 || if_exccode !== 5'd4 || fetch_cnt !== 32'd8) begin n_fail++; $display("FAIL seq_past_end: got pc %h exc %0d cnt %0d expected 00007000 4 8", if_pc, if_exccode, fetch_cnt); end
        eret_req = 1; epc = 32'h2ffc;
        step();
        n_chk++; if (if_exccode !== 5'd4) begin n_fail++; $display("FAIL below_base: got exc %0d expected 4", if_exccode); end
        epc = 32'hffff_fffc;
        step();
        eret_req = 0;
        step();
        n_chk++; if (if_pc !== 32'h0 || if_exccode !== 5'd4 || fetch_cnt !== 32'd9) begin n_fail++; $display("FAIL pc_wrap: got pc %h exc %0d cnt %0d expected 00000000 4 9", if_pc, if_exccode, fetch_cnt); end
    endtask

    task automatic test_reset_mid_run();
        eret_req = 1; epc = 32'h3020;
        step();
        eret_req = 0; stall = 1; br_valid = 1; br_target = 32'h3400;
        step();
        reset = 1; stall = 0; br_valid = 0;
        step();
        n_chk++; if (if_pc !== 32'h3000 || if_valid !== 1'b0 || fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL midreset: got pc %h valid %b cnt %0d expected 00003000 0 0", if_pc, if_valid, fetch_cnt); end
        reset = 0;
        step();
        n_chk++; if (if_pc !== 32'h3000 || if_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_run: got pc %h valid %b expected 00003000 1", if_pc, if_valid); end
        step();
        n_chk++; if (if_pc !== 32'h3004) begin n_fail++; $display("FAIL midreset_pend_gone: got %h expected 00003004", if_pc); end
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(7))
            0:       return $urandom;
            1:       return 32'h3000 + 32'($urandom_range(4095)) * 4 + 32'($urandom_range(3, 1));
            default: return 32'h3000 + 32'($urandom_range(4095)) * 4;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] e_instr;
        logic [4:0]  e_exc;
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(99) == 0);
            stall     = ($urandom_range(9) < 3);
            br_valid  = ($urandom_range(3) == 0);
            exc_req   = ($urandom_range(29) == 0);
            eret_req  = ($urandom_range(29) == 0);
            br_target = rand_pc();
            if (br_target == m_pc) br_target = br_target + 4;
            epc       = rand_pc();
            step();
            e_exc   = (m_run && addr_err(m_pc)) ? 5'd4 : 5'd0;
            e_instr = (m_run && !addr_err(m_pc)) ? im_word(m_pc) : 32'h0;
            n_chk++; if (if_pc !== m_pc || im_addr !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got pc %h addr %h expected %h", i, if_pc, im_addr, m_pc); end
            n_chk++; if (if_valid !== m_run) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, if_valid, m_run); end
            n_chk++; if (if_exccode !== e_exc) begin n_fail++; $display("FAIL rnd_exc[%0d]: got %0d expected %0d", i, if_exccode, e_exc); end
            n_chk++; if (if_instr !== e_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, if_instr, e_instr); end
            n_chk++; if (fetch_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, fetch_cnt, m_cnt); end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_run = 1'b0;
        m_pc  = 32'h3000;
        m_cnt = 0;
        test_reset();
        test_stall();
        test_pending_branch();
        test_exception();
        test_eret_adel();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
